// File: rtl/hyperbus_pkg.sv
// Shared definitions for the Wishbone-to-HyperBus bridge: word widths
// and the one-hot bridge FSM state encoding.
package hyperbus_pkg;

    localparam int HB_WORD = 16;
    localparam int WB_WORD = 32;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'b0001,
        ST_WRITE = 4'b0010,
        ST_READ  = 4'b0100,
        ST_DONE  = 4'b1000
    } bridge_state_t;

endpackage

// File: rtl/hyperbus_wb_bridge.sv
// Wishbone B4 classic 32-bit slave in front of the HyperBus leader controller.
// Each WB access becomes one or two 16-bit controller beats on wrq/rrq;
// read beats are assembled into a 32-bit word returned with a single ack.
// Optional build macro HBUS_BRIDGE_TIMEOUT_EN adds a stall watchdog that
// aborts a request after TIMEOUT_CYCLES idle cycles and answers with wb_err_o.
module hyperbus_wb_bridge
    import hyperbus_pkg::*;
#(
    parameter int ADDR_LENGTH    = 32,
    parameter int REG_SPACE_BIT  = 31,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic [ADDR_LENGTH-1:0] wb_adr_i,
    input  logic [WB_WORD-1:0]     wb_dat_i,
    input  logic [3:0]             wb_sel_i,
    input  logic                   wb_we_i,
    input  logic                   wb_cyc_i,
    input  logic                   wb_stb_i,
    output logic [WB_WORD-1:0]     wb_dat_o,
    output logic                   wb_ack_o,
    output logic                   wb_err_o,
    output logic [ADDR_LENGTH-1:0] hb_adr_o,
    output logic                   hb_reg_space_o,
    output logic [HB_WORD-1:0]     hb_dat_o,
    output logic [2:0]             hb_mask_o,
    output logic                   hb_wrq_o,
    output logic                   hb_rrq_o,
    input  logic                   hb_ready_i,
    input  logic                   hb_valid_i,
    input  logic [HB_WORD-1:0]     hb_dat_i
);

    bridge_state_t          state_q, state_d;
    logic [1:0]             nbeats_q;
    logic                   beat_q;
    logic                   drop_q;
    logic [WB_WORD-1:0]     dat_q;
    logic [3:0]             sel_q;
    logic [ADDR_LENGTH-1:0] adr_half;
    logic                   start, last_beat, wr_fire, rd_fire, beat_fire;
    logic                   finish, tmo_hit, tmo_flag;

    // The ack/err cycle itself must not restart the access the master still strobes
    assign start     = (state_q == ST_IDLE) && wb_cyc_i && wb_stb_i && !wb_ack_o && !wb_err_o;
    assign last_beat = ({1'b0, beat_q} == (nbeats_q - 2'd1));
    assign wr_fire   = (state_q == ST_WRITE) && hb_wrq_o && hb_ready_i;
    assign rd_fire   = (state_q == ST_READ) && hb_rrq_o && hb_valid_i;
    assign beat_fire = wr_fire || rd_fire;
    assign finish    = (beat_fire && last_beat) || tmo_hit;

    // Halfword address of the 32-bit word, register-space select removed
    always_comb begin
        adr_half                  = wb_adr_i >> 1;
        adr_half[0]               = 1'b0;
        adr_half[REG_SPACE_BIT-1] = 1'b0;
    end

    // FSM state register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // FSM next-state decode
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:           if (start) state_d = wb_we_i ? ST_WRITE : ST_READ;
            ST_WRITE, ST_READ: if (finish) state_d = ST_DONE;
            ST_DONE:           state_d = ST_IDLE;
            default:           state_d = ST_IDLE;
        endcase
    end

    // Access capture, beat sequencing, read assembly and registered outputs
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            nbeats_q       <= 2'd0;
            beat_q         <= 1'b0;
            drop_q         <= 1'b0;
            dat_q          <= '0;
            sel_q          <= '0;
            wb_dat_o       <= '0;
            wb_ack_o       <= 1'b0;
            hb_adr_o       <= '0;
            hb_reg_space_o <= 1'b0;
            hb_dat_o       <= '0;
            hb_mask_o      <= '0;
            hb_wrq_o       <= 1'b0;
            hb_rrq_o       <= 1'b0;
        end else begin
            wb_ack_o <= 1'b0;
            if (start) begin
                nbeats_q       <= wb_adr_i[REG_SPACE_BIT] ? 2'd1 : 2'd2;
                beat_q         <= 1'b0;
                drop_q         <= 1'b0;
                dat_q          <= wb_dat_i;
                sel_q          <= wb_sel_i;
                hb_adr_o       <= adr_half;
                hb_reg_space_o <= wb_adr_i[REG_SPACE_BIT];
                hb_dat_o       <= wb_we_i ? wb_dat_i[HB_WORD-1:0] : '0;
                hb_mask_o      <= wb_we_i ? {1'b0, ~wb_sel_i[1:0]} : 3'b000;
            end
            // A master that gives up mid-transaction gets no ack, but the burst finishes
            if (state_q != ST_IDLE && !wb_cyc_i) drop_q <= 1'b1;
            // Request rises one cycle after entering WRITE/READ
            if (state_q == ST_WRITE && !hb_wrq_o && !finish) hb_wrq_o <= 1'b1;
            if (state_q == ST_READ && !hb_rrq_o && !finish)  hb_rrq_o <= 1'b1;
            if (wr_fire && !last_beat) begin
                beat_q    <= 1'b1;
                hb_dat_o  <= dat_q[WB_WORD-1:HB_WORD];
                hb_mask_o <= {1'b0, ~sel_q[3:2]};
            end
            if (rd_fire) begin
                if (nbeats_q == 2'd1) wb_dat_o <= {{(WB_WORD-HB_WORD){1'b0}}, hb_dat_i};
                else if (beat_q)      wb_dat_o[WB_WORD-1:HB_WORD] <= hb_dat_i;
                else                  wb_dat_o[HB_WORD-1:0] <= hb_dat_i;
                if (!last_beat) beat_q <= 1'b1;
            end
            if (finish) begin
                hb_wrq_o <= 1'b0;
                hb_rrq_o <= 1'b0;
            end
            if (state_q == ST_DONE) wb_ack_o <= !drop_q && wb_cyc_i && !tmo_flag;
        end
    end

`ifdef HBUS_BRIDGE_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TMO_W-1:0] tmo_cnt_q;
    logic             tmo_flag_q;

    assign tmo_hit  = (hb_wrq_o || hb_rrq_o) && !beat_fire &&
                      (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1));
    assign tmo_flag = tmo_flag_q;

    // Stall watchdog: counts request cycles without a beat, aborts on expiry
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tmo_cnt_q  <= '0;
            tmo_flag_q <= 1'b0;
            wb_err_o   <= 1'b0;
        end else begin
            wb_err_o <= 1'b0;
            if (start) tmo_flag_q <= 1'b0;
            if (!(hb_wrq_o || hb_rrq_o) || beat_fire) tmo_cnt_q <= '0;
            else                                      tmo_cnt_q <= tmo_cnt_q + 1'b1;
            if (tmo_hit) tmo_flag_q <= 1'b1;
            if (state_q == ST_DONE) wb_err_o <= !drop_q && wb_cyc_i && tmo_flag_q;
        end
    end
`else
    // Without the watchdog the bridge waits forever and never errors
    logic unused_tmo;
    assign unused_tmo = (TIMEOUT_CYCLES != 0);
    assign tmo_hit    = 1'b0;
    assign tmo_flag   = 1'b0;
    assign wb_err_o   = 1'b0;
`endif

endmodule

// File: tb/tb_hyperbus_wb_bridge.sv
// Randomized self-checking bench for hyperbus_wb_bridge. The bench plays
// both the Wishbone master and the HyperBus controller and predicts every
// address, beat, mask, read word and ack from the access it issued.
module tb_hyperbus_wb_bridge;

    logic        clk = 1'b0;
    logic        rstn;
    logic [31:0] wb_adr_i, wb_dat_i, wb_dat_o;
    logic [3:0]  wb_sel_i;
    logic        wb_we_i, wb_cyc_i, wb_stb_i, wb_ack_o, wb_err_o;
    logic [31:0] hb_adr_o;
    logic        hb_reg_space_o, hb_wrq_o, hb_rrq_o, hb_ready_i, hb_valid_i;
    logic [15:0] hb_dat_o, hb_dat_i;
    logic [2:0]  hb_mask_o;

    int n_vec = 0;
    int n_bad = 0;

    hyperbus_wb_bridge #(
        .ADDR_LENGTH(32), .REG_SPACE_BIT(31), .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk), .rstn(rstn),
        .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_sel_i(wb_sel_i),
        .wb_we_i(wb_we_i), .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i),
        .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o),
        .hb_adr_o(hb_adr_o), .hb_reg_space_o(hb_reg_space_o),
        .hb_dat_o(hb_dat_o), .hb_mask_o(hb_mask_o),
        .hb_wrq_o(hb_wrq_o), .hb_rrq_o(hb_rrq_o),
        .hb_ready_i(hb_ready_i), .hb_valid_i(hb_valid_i), .hb_dat_i(hb_dat_i)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One complete Wishbone access with the bench acting as controller.
    // Entered and left on a negative clock edge.
    task automatic wb_access(input bit we, input logic [31:0] adr, input logic [31:0] dat,
                             input logic [3:0] sel, input bit drop_cyc);
        bit          is_reg;
        int          nb, idx, cyc_n;
        logic [31:0] exp_adr, exp_rd;
        logic [15:0] beat_d [2];
        logic [2:0]  beat_m [2];
        logic [15:0] rb     [2];
        is_reg    = adr[31];
        nb        = is_reg ? 1 : 2;
        exp_adr   = (adr >> 1) & ~32'h1 & ~32'h4000_0000;
        beat_d[0] = dat[15:0];
        beat_d[1] = dat[31:16];
        beat_m[0] = {1'b0, ~sel[1:0]};
        beat_m[1] = {1'b0, ~sel[3:2]};
        rb[0]     = 16'($urandom);
        rb[1]     = 16'($urandom);
        exp_rd    = is_reg ? {16'h0, rb[0]} : {rb[1], rb[0]};

        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we;
        wb_adr_i = adr;  wb_dat_i = dat;  wb_sel_i = sel;
        @(negedge clk);
        check("req_latency", {hb_wrq_o, hb_rrq_o}, 2'b00);
        check("hb_adr", hb_adr_o, exp_adr);
        check("reg_space", hb_reg_space_o, is_reg);
        @(negedge clk);
        check("req_on", {hb_wrq_o, hb_rrq_o}, we ? 2'b10 : 2'b01);
        if (drop_cyc) begin wb_cyc_i = 1'b0; wb_stb_i = 1'b0; end

        idx = 0; cyc_n = 0;
        while (idx < nb && cyc_n < 200) begin
            check("req_held", {hb_wrq_o, hb_rrq_o}, we ? 2'b10 : 2'b01);
            if (we) begin
                hb_ready_i = ($urandom_range(0, 2) != 0);
                if (hb_ready_i) begin
                    check("beat_dat", hb_dat_o, beat_d[idx]);
                    check("beat_mask", hb_mask_o, beat_m[idx]);
                    idx++;
                end
            end else begin
                hb_valid_i = ($urandom_range(0, 2) != 0);
                if (hb_valid_i) begin hb_dat_i = rb[idx]; idx++; end
                else hb_dat_i = 16'($urandom);
            end
            @(negedge clk);
            cyc_n++;
        end
        if (idx < nb) check("beats_budget", idx, nb);

        // Controller still signals during the falling request cycle
        check("req_off", {hb_wrq_o, hb_rrq_o}, 2'b00);
        check("ack_early", wb_ack_o, 1'b0);
        if (we) hb_ready_i = 1'b1;
        else begin hb_valid_i = 1'b1; hb_dat_i = 16'($urandom); end
        @(negedge clk);
        hb_ready_i = 1'b0; hb_valid_i = 1'b0;
        check("ack", wb_ack_o, !drop_cyc);
        check("err_with_ack", wb_err_o, 1'b0);
        if (!we && !drop_cyc) check("rdata", wb_dat_o, exp_rd);
        // Classic master keeps strobing through the ack cycle
        @(negedge clk);
        check("ack_pulse", wb_ack_o, 1'b0);
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        @(negedge clk);
        check("no_restart", {hb_wrq_o, hb_rrq_o, wb_ack_o}, 3'b000);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rstn = 1'b0;
        wb_adr_i = '0; wb_dat_i = '0; wb_sel_i = '0; wb_we_i = 1'b0;
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        hb_ready_i = 1'b0; hb_valid_i = 1'b0; hb_dat_i = '0;
        repeat (2) @(negedge clk);
        check("rst_req", {hb_wrq_o, hb_rrq_o, wb_ack_o, wb_err_o}, 4'b0000);
        check("rst_adr", hb_adr_o, 32'h0);
        check("rst_wbdat", wb_dat_o, 32'h0);
        rstn = 1'b1;
        @(negedge clk);

        // Directed cases
        wb_access(1'b1, 32'h0000_0100, 32'h1234_5678, 4'hF, 1'b0);
        wb_access(1'b1, 32'h0000_0200, 32'hA5A5_5A5A, 4'h2, 1'b0);
        wb_access(1'b0, 32'h0000_0040, 32'h0, 4'hF, 1'b0);
        wb_access(1'b0, 32'h8000_0000, 32'h0, 4'hF, 1'b0);
        wb_access(1'b0, 32'h0000_0084, 32'h0, 4'hF, 1'b1);

        // Randomized accesses
        for (int i = 0; i < 40; i++) begin
            logic [31:0] adr;
            adr = {($urandom_range(0, 3) == 0), 31'($urandom)};
            wb_access(1'($urandom_range(0, 1)), adr, $urandom, 4'($urandom),
                      ($urandom_range(0, 7) == 0));
        end

`ifdef HBUS_BRIDGE_TIMEOUT_EN
        begin
            int hi, errs, acks;
            wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = 32'h44;
            @(negedge clk); @(negedge clk);
            hi = 0;
            while (hb_rrq_o && hi < 100) begin hi++; @(negedge clk); end
            check("tmo_len", hi, 16);
            errs = 0; acks = 0;
            repeat (4) begin
                @(negedge clk);
                errs += int'(wb_err_o);
                acks += int'(wb_ack_o);
                if (wb_err_o || wb_ack_o) begin wb_cyc_i = 1'b0; wb_stb_i = 1'b0; end
            end
            wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
            check("tmo_err_cnt", errs, 1);
            check("tmo_ack_cnt", acks, 0);
            @(negedge clk);
        end
`endif

        // Asynchronous reset in the middle of a write
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1;
        wb_adr_i = 32'h300; wb_dat_i = 32'hCAFE_F00D; wb_sel_i = 4'hF;
        @(negedge clk); @(negedge clk);
        check("rst_pre_wrq", hb_wrq_o, 1'b1);
        #2 rstn = 1'b0;
        #1;
        check("arst_req", {hb_wrq_o, hb_rrq_o, wb_ack_o, wb_err_o, hb_reg_space_o}, 5'b0);
        check("arst_adr", hb_adr_o, 32'h0);
        check("arst_hbdat", {hb_dat_o, hb_mask_o}, 19'h0);
        check("arst_wbdat", wb_dat_o, 32'h0);
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        wb_access(1'b1, 32'h0000_0300, 32'h0BAD_BEEF, 4'h9, 1'b0);
        wb_access(1'b0, 32'h0000_0300, 32'h0, 4'hF, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
